// File: rtl/counter_seq_checker.sv
// Receive-side checker for a mod-MOD count stream: locks after LOCK_LEN correct samples
// starting at 0, then flags sequence breaks and counts errors and wraps.
`timescale 1ns/1ps
module counter_seq_checker #(
   parameter int MOD      = 5,
   parameter int LOCK_LEN = 5,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       in,
   output logic             locked,
   output logic             wrap_pulse,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

   localparam logic [2:0] LAST   = 3'(MOD - 1);
   localparam logic [3:0] LOCK_N = 4'(LOCK_LEN);

   state_t           state_reg, state_next;
   logic [2:0]       exp_reg, exp_next;
   logic [3:0]       good_reg, good_next;
   logic             wrap_reg, wrap_next;
   logic             err_reg, err_next;
   logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;
   logic             match;

   function automatic logic [2:0] next_val(input logic [2:0] v);
      return (v == LAST) ? 3'd0 : v + 3'd1;
   endfunction

   // exp_reg is always below MOD, so out-of-range inputs can never match
   assign match = (in == exp_reg);

   always_comb begin
      state_next   = state_reg;
      exp_next     = exp_reg;
      good_next    = good_reg;
      wrap_next    = 1'b0;
      err_next     = 1'b0;
      err_cnt_next = err_cnt_reg;
      if (en) begin
         case (state_reg)
            HUNT: begin
               if (in == 3'd0) begin
                  exp_next   = next_val(3'd0);
                  good_next  = 4'd1;
                  state_next = (LOCK_LEN == 1) ? LOCKED : TRACK;
               end
            end
            TRACK: begin
               if (match) begin
                  exp_next  = next_val(exp_reg);
                  good_next = good_reg + 4'd1;
                  // the sample that completes the run also counts as a locked wrap
                  if (good_reg + 4'd1 == LOCK_N) begin
                     state_next = LOCKED;
                     wrap_next  = (in == LAST);
                  end
               end else if (in == 3'd0) begin
                  exp_next  = next_val(3'd0);
                  good_next = 4'd1;
               end else begin
                  good_next  = 4'd0;
                  state_next = HUNT;
               end
            end
            LOCKED: begin
               if (match) begin
                  exp_next  = next_val(exp_reg);
                  wrap_next = (in == LAST);
               end else begin
                  err_next = 1'b1;
                  if (err_cnt_reg != {ERR_W{1'b1}})
                     err_cnt_next = err_cnt_reg + 1'b1;
                  if (in == 3'd0) begin
                     exp_next   = next_val(3'd0);
                     good_next  = 4'd1;
                     state_next = (LOCK_LEN == 1) ? LOCKED : TRACK;
                  end else begin
                     good_next  = 4'd0;
                     state_next = HUNT;
                  end
               end
            end
            default: state_next = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= HUNT;
         exp_reg     <= 3'd0;
         good_reg    <= 4'd0;
         wrap_reg    <= 1'b0;
         err_reg     <= 1'b0;
         err_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         exp_reg     <= exp_next;
         good_reg    <= good_next;
         wrap_reg    <= wrap_next;
         err_reg     <= err_next;
         err_cnt_reg <= err_cnt_next;
      end
   end

   assign locked     = (state_reg == LOCKED);
   assign wrap_pulse = wrap_reg;
   assign err_pulse  = err_reg;
   assign err_cnt    = err_cnt_reg;

endmodule
